// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pooling stream controller.
package pool_pkg;

  // Default pixel width: one IEEE-754 single-precision value.
  localparam int POOL_DATA_W = 32;

  // Width of the pooled-pixel raster index presented alongside each result.
  localparam int OUT_IDX_W = 16;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  // One pixel at the default width.
  typedef logic [POOL_DATA_W-1:0] pixel_t;

  // A window closes on the bottom-right pixel of each 2x2 block, which is
  // an odd row and an odd column in zero-based raster coordinates.
  function automatic logic window_closes(input logic row_lsb, input logic col_lsb);
    return row_lsb & col_lsb;
  endfunction

  // The top row of a 2x2 block lives in the line buffer; even rows fill it.
  function automatic logic top_row(input logic row_lsb);
    return ~row_lsb;
  endfunction

  // The bottom-left pixel of a block arrives on an odd row, even column.
  function automatic logic bottom_left(input logic row_lsb, input logic col_lsb);
    return row_lsb & ~col_lsb;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: a single synchronous write port and two
// asynchronous read ports so both top-row pixels of a window are
// available in the same cycle as the bottom-right pixel.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int DEPTH  = 28,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  input  logic [AW-1:0]     rd_addr1,
  output logic [DATA_W-1:0] rd_data1
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Capture the current even-row pixel at its column position.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Stream sequencer for a 2x2 / stride-2 max-pooling datapath. Pixels
// arrive in raster order; even rows are parked in a line buffer, the
// bottom-left pixel of each block is held in a register, and the
// bottom-right pixel completes the window, which is presented to the
// datapath combinationally. The pooled value is flagged one cycle later
// when the datapath's registered output is valid.
module maxpool_stream_ctrl
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int CW     = $clog2(IMG_W),
  parameter int RW     = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [DATA_W-1:0]    dp_in0,
  output logic [DATA_W-1:0]    dp_in1,
  output logic [DATA_W-1:0]    dp_in2,
  output logic [DATA_W-1:0]    dp_in3,
  input  logic [DATA_W-1:0]    dp_out,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_IDX_W-1:0] out_idx
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  pool_state_t       state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;

  logic              accept;
  logic              issue;
  logic              last_pixel;
  logic              lb_wr_en;
  logic              bl_load;
  logic [CW-1:0]     rd_addr_left;
  logic [DATA_W-1:0] lb_left;
  logic [DATA_W-1:0] lb_right;
  logic [DATA_W-1:0] bl_hold;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;
  logic [DATA_W-1:0] hold2;
  logic [DATA_W-1:0] hold3;

  // in_ready is only ever high in RUN, so an accept implies RUN.
  assign accept     = in_valid & in_ready;
  assign issue      = accept & window_closes(row[0], col[0]);
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
  assign lb_wr_en   = accept & top_row(row[0]);
  assign bl_load    = accept & bottom_left(row[0], col[0]);

  // Windows only close on odd columns, so col-1 never underflows when used.
  assign rd_addr_left = col - CW'(1);

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en    (lb_wr_en),
    .wr_addr  (col),
    .wr_data  (in_data),
    .rd_addr0 (rd_addr_left),
    .rd_data0 (lb_left),
    .rd_addr1 (col),
    .rd_data1 (lb_right)
  );

  // Sequencing FSM: owns the raster counters, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      col      <= '0;
      row      <= '0;
      out_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (out_valid) begin
        out_idx <= out_idx + OUT_IDX_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            col      <= '0;
            row      <= '0;
            out_idx  <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_pixel) begin
              col      <= '0;
              row      <= '0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Park the bottom-left pixel until the bottom-right one closes the window.
  always_ff @(posedge clk) begin
    if (bl_load) begin
      bl_hold <= in_data;
    end
  end

  // Remember the last issued window so the datapath inputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
      hold2 <= '0;
      hold3 <= '0;
    end else if (issue) begin
      hold0 <= lb_left;
      hold1 <= lb_right;
      hold2 <= bl_hold;
      hold3 <= in_data;
    end
  end

  assign dp_in0 = issue ? lb_left  : hold0;
  assign dp_in1 = issue ? lb_right : hold1;
  assign dp_in2 = issue ? bl_hold  : hold2;
  assign dp_in3 = issue ? in_data  : hold3;

  // The datapath registers its result, so the valid flag trails issue by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= issue;
    end
  end

  assign out_data = dp_out;

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Bench for maxpool_stream_ctrl: a 4x4 instance and a 5x3 instance, each
// fed by a behavioural float-max datapath, checked every cycle against a
// raster-position reference model.
module tb_maxpool_stream_ctrl;
  import pool_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, in_valid;
  logic [31:0] in_data;

  logic        a_busy, a_done, a_in_ready, a_out_valid;
  logic [31:0] a_dp0, a_dp1, a_dp2, a_dp3, a_dp_out, a_out_data;
  logic [15:0] a_out_idx;
  logic        b_busy, b_done, b_in_ready, b_out_valid;
  logic [31:0] b_dp0, b_dp1, b_dp2, b_dp3, b_dp_out, b_out_data;
  logic [15:0] b_out_idx;

  maxpool_stream_ctrl #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .dp_in0(a_dp0), .dp_in1(a_dp1), .dp_in2(a_dp2), .dp_in3(a_dp3),
    .dp_out(a_dp_out), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_idx(a_out_idx)
  );

  maxpool_stream_ctrl #(.DATA_W(32), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .dp_in0(b_dp0), .dp_in1(b_dp1), .dp_in2(b_dp2), .dp_in3(b_dp3),
    .dp_out(b_dp_out), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_idx(b_out_idx)
  );

  // Float ordering via sign-magnitude to unsigned key.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax2(input logic [31:0] x, input logic [31:0] y);
    return (fkey(x) >= fkey(y)) ? x : y;
  endfunction

  function automatic logic [31:0] fmax4(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
    return fmax2(fmax2(w0, w1), fmax2(w2, w3));
  endfunction

  // Small positive integer to IEEE-754 single.
  function automatic logic [31:0] int_to_f32(input int v);
    int e;
    logic [31:0] m;
    e = 0;
    for (int i = 0; i < 24; i++) if (v >= (1 << i)) e = i;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Behavioural datapath: registered max of the four window inputs.
  always @(posedge clk) begin
    a_dp_out <= fmax4(a_dp0, a_dp1, a_dp2, a_dp3);
    b_dp_out <= fmax4(b_dp0, b_dp1, b_dp2, b_dp3);
  end

  // Observation mux selecting the instance under test.
  logic        sel;
  logic        o_ready, o_busy, o_done, o_ov;
  logic [31:0] o_data, o_dp0, o_dp1, o_dp2, o_dp3;
  logic [15:0] o_idx;

  always_comb begin
    o_ready = sel ? b_in_ready  : a_in_ready;
    o_busy  = sel ? b_busy      : a_busy;
    o_done  = sel ? b_done      : a_done;
    o_ov    = sel ? b_out_valid : a_out_valid;
    o_data  = sel ? b_out_data  : a_out_data;
    o_idx   = sel ? b_out_idx   : a_out_idx;
    o_dp0   = sel ? b_dp0       : a_dp0;
    o_dp1   = sel ? b_dp1       : a_dp1;
    o_dp2   = sel ? b_dp2       : a_dp2;
    o_dp3   = sel ? b_dp3       : a_dp3;
  end

  // Reference model state.
  int          cur_w, cur_h;
  int          n_vec, n_err;
  logic        ex_ready, ex_ov, last_acc;
  int          tail;
  int          out_cnt;
  int          acc;
  pixel_t      acc_pix [64];
  pixel_t      ex_win [4];
  pixel_t      ex_max;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    cmp("in_ready", {31'd0, o_ready}, {31'd0, ex_ready});
    cmp("busy", {31'd0, o_busy}, {31'd0, ex_ready || (tail == 1)});
    cmp("done", {31'd0, o_done}, {31'd0, tail == 2});
    cmp("out_valid", {31'd0, o_ov}, {31'd0, ex_ov});
    if (ex_ov) begin
      cmp("out_data", o_data, ex_max);
      cmp("out_idx", {16'd0, o_idx}, 32'(out_cnt));
      cmp("dp_in0", o_dp0, ex_win[0]);
      cmp("dp_in1", o_dp1, ex_win[1]);
      cmp("dp_in2", o_dp2, ex_win[2]);
      cmp("dp_in3", o_dp3, ex_win[3]);
    end
  endtask

  // One clock cycle: drive inputs, check current outputs, advance the model.
  task automatic apply_stimulus(input logic s, input logic v, input logic [31:0] d, input logic r);
    logic idle, iss;
    int   p, pr, pc;
    rst      = r;
    start_a  = s && !sel;
    start_b  = s && sel;
    in_valid = v;
    in_data  = d;
    #1;
    check_output();
    last_acc = 1'b0;
    if (r) begin
      ex_ready = 1'b0;
      tail     = 0;
      ex_ov    = 1'b0;
      out_cnt  = 0;
    end else begin
      idle = !ex_ready && (tail == 0);
      iss  = 1'b0;
      if (ex_ov) out_cnt++;
      tail = (tail == 1) ? 2 : 0;
      if (idle && s) begin
        ex_ready = 1'b1;
        acc      = 0;
        out_cnt  = 0;
      end else if (ex_ready && v) begin
        p  = acc;
        pr = p / cur_w;
        pc = p % cur_w;
        acc_pix[p] = d;
        last_acc   = 1'b1;
        if ((pr % 2 == 1) && (pc % 2 == 1)) begin
          iss       = 1'b1;
          ex_win[0] = acc_pix[p - cur_w - 1];
          ex_win[1] = acc_pix[p - cur_w];
          ex_win[2] = acc_pix[p - 1];
          ex_win[3] = d;
          ex_max    = fmax4(ex_win[0], ex_win[1], ex_win[2], ex_win[3]);
        end
        acc++;
        if (acc == cur_w * cur_h) begin
          ex_ready = 1'b0;
          tail     = 1;
        end
      end
      ex_ov = iss;
    end
    @(negedge clk);
  endtask

  // Stream one map. pat: 0 sequential 1.0.., 1 random, 2 corner maxima.
  // gap: 0 constant valid, 1 toggling, 2 random gaps.
  task automatic run_map(input int pat, input int gap, input int start_at, input int rst_at);
    pixel_t px [64];
    int     n, k, cyc, rr, cc;
    logic   v;
    n = cur_w * cur_h;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0: px[i] = int_to_f32(i + 1);
        1: px[i] = {1'b0, 8'($urandom_range(120, 134)), 23'($urandom)};
        default: px[i] = 32'h3F80_0000;
      endcase
    end
    if (pat == 2) begin
      // Max at TL of block 0, TR of block 1, BL of block 2, BR of block 3.
      rr = 0; cc = 0; px[rr * cur_w + cc] = 32'h4020_0000;
      rr = 0; cc = 3; px[rr * cur_w + cc] = 32'h4020_0000;
      rr = 3; cc = 0; px[rr * cur_w + cc] = 32'h4020_0000;
      rr = 3; cc = 3; px[rr * cur_w + cc] = 32'h4020_0000;
    end
    apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      case (gap)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (k == rst_at && v) begin
        apply_stimulus(1'b0, 1'b1, px[k], 1'b1);
        break;
      end
      apply_stimulus(cyc == start_at, v, px[k], 1'b0);
      if (last_acc) k++;
      cyc++;
    end
    if (cyc >= 400) begin
      n_err++;
      $display("[TB] FAIL map_timeout: accepted %0d of %0d pixels", k, n);
    end
    repeat (4) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    sel = 1'b0; cur_w = 4; cur_h = 4;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    n_vec = 0; n_err = 0;
    ex_ready = 1'b0; ex_ov = 1'b0; last_acc = 1'b0; tail = 0; out_cnt = 0; acc = 0;
    ex_max = '0;
    for (int i = 0; i < 4; i++) ex_win[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check_output();
    cmp("rst_out_idx", {16'd0, o_idx}, 32'd0);
    cmp("rst_dp_in0", o_dp0, 32'd0);
    cmp("rst_dp_in1", o_dp1, 32'd0);
    cmp("rst_dp_in2", o_dp2, 32'd0);
    cmp("rst_dp_in3", o_dp3, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);

    $display("[TB] 4x4 sequential map, constant valid");
    run_map(0, 0, -1, -1);
    $display("[TB] 4x4 sequential map, toggling valid");
    run_map(0, 1, -1, -1);
    $display("[TB] 4x4 corner-max windows");
    run_map(2, 0, -1, -1);
    $display("[TB] 4x4 reset at pixel 9");
    run_map(0, 0, -1, 8);
    $display("[TB] 4x4 fresh map after reset");
    run_map(0, 0, -1, -1);
    $display("[TB] 4x4 start pulsed during RUN");
    run_map(0, 0, 5, -1);
    $display("[TB] 4x4 random maps with random gaps");
    repeat (3) run_map(1, 2, -1, -1);
    run_map(1, 0, -1, -1);

    $display("[TB] 5x3 sequential map");
    sel = 1'b1; cur_w = 5; cur_h = 3;
    run_map(0, 0, -1, -1);
    run_map(1, 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_stream_ctrl.md
Name: maxpool_stream_ctrl

Overview:
- Sequences the 2x2/stride-2 float32 max-pooling datapath (`max_pooling`, 1-cycle registered latency) over one feature map per `start`.
- Accepts the map as a raster pixel stream (valid/ready) and holds even rows in a line buffer.
- On each bottom-right pixel it presents a full 2x2 window to the datapath.
- Flags the pooled result one cycle later.
- Sits between a layer's activation output stream and the next layer's input buffer; usable unchanged for layers 1-3 via parameters.

Parameters:
- DATA_W, 32, pixel width (IEEE-754 single).
- IMG_W, 28, input map width in pixels (>=2).
- IMG_H, 28, input map height in pixels (>=2).
- CW, $clog2(IMG_W), column counter width (derived).
- RW, $clog2(IMG_H), row counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle pulse; begins one map; honoured only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  1-cycle pulse after the last pooled output.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  high only in RUN.
- in_data  in  DATA_W  pixel, raster order.
- dp_in0  out  DATA_W  window top-left, to datapath `data_in0`.
- dp_in1  out  DATA_W  window top-right, to datapath `data_in1`.
- dp_in2  out  DATA_W  window bottom-left, to datapath `data_in2`.
- dp_in3  out  DATA_W  window bottom-right, to datapath `data_in3`.
- dp_out  in  DATA_W  datapath `data_out`.
- out_valid  out  1  `dp_out` holds a new pooled pixel this cycle.
- out_data  out  DATA_W  = `dp_out` (pass-through).
- out_idx  out  16  raster index of the pooled pixel, 0..(IMG_W/2)*(IMG_H/2)-1.

Behaviour:
- Reset values:
  - State IDLE.
  - `busy`, `done`, `in_ready`, `out_valid` = 0.
  - `out_idx` = 0, `dp_in0..3` = 0.
  - col/row counters = 0.
  - Line buffer contents are don't-care.
- Reset mid-map: abandons the map immediately; no `done`; partial outputs already flagged stand.
- FSM:
  - IDLE: `start` clears counters and `out_idx` -> RUN.
  - RUN: accept pixels. On the accept of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: one cycle for datapath latency -> DONE.
  - DONE: `done`=1 for one cycle -> IDLE.
  - `start` outside IDLE is ignored.
- Accept means `in_valid` && `in_ready`. `in_valid` while `in_ready`=0 is ignored.
- Each accept advances col; at col==IMG_W-1 col wraps to 0 and row increments.
- Even row: write `in_data` to lb[col].
- Odd row, even col: register `in_data` into `bl_hold`.
- Odd row, odd col (window issue):
  - `dp_in0` = lb[col-1], `dp_in1` = lb[col], `dp_in2` = `bl_hold`, `dp_in3` = `in_data`.
  - `dp_in*` are combinational on the issue cycle.
  - `issue` = 1 for that cycle; `dp_in*` hold their last value otherwise.
- Latency: `out_valid` = `issue` delayed exactly 1 cycle, aligned with the registered `dp_out`.
- `out_idx` increments after each `out_valid` cycle.
- Odd IMG_W: last column is accepted but never windowed. Odd IMG_H: last row is accepted, written to lb, never windowed.
- Total outputs per map = floor(IMG_W/2)*floor(IMG_H/2).
- Back-to-back maps: `start` may be asserted in the cycle after `done`.
- Stalls: `in_valid` gaps are legal anywhere; the window state (`bl_hold`, lb) holds across gaps.
- No output backpressure: the consumer must accept every `out_valid`.
- The block passes data unmodified. Sign/float handling belongs to the datapath.
- The datapath's own reset is tied externally. The controller does not depend on `dp_out` outside `out_valid` cycles.

Decomposition:
- Package `pool_pkg`:
  - `DATA_W` default.
  - State enum `pool_state_t` {IDLE, RUN, DRAIN, DONE}.
  - Typedef `pixel_t` (logic [DATA_W-1:0]).
- Sub-module `pool_line_buffer`: IMG_W x DATA_W; 1 synchronous write port; 2 asynchronous read ports (addr `col-1`, `col`).

Test Plan:
- IMG_W=4, IMG_H=4, pixels 1.0..16.0 (0x3F800000 etc.) streamed with `in_valid` constant -> 4 outputs:
  - 6.0 (0x40C00000), 8.0 (0x41000000), 14.0 (0x41600000), 16.0 (0x41800000).
  - `out_idx` 0..3; each `out_valid` one cycle after the accept of pixels 6, 8, 14, 16.
  - `done` 2 cycles after the last accept.
- Same map with `in_valid` toggled 1,0,1,0 -> identical outputs and order; `out_valid` still 1 cycle after each issuing accept.
- Window with max at each corner position (e.g. {2.5,1,1,1}, {1,2.5,1,1}, …) -> `dp_in0..3` routing verified; output 2.5 (0x40200000) each time.
- `rst` asserted at pixel 9 of a 4x4 map -> next cycle IDLE, `in_ready`=0, no `done`. Fresh `start` + full map -> correct 4 outputs from `out_idx` 0.
- `start` pulsed during RUN -> ignored: counters unchanged, exactly 4 outputs, one `done`.
- IMG_W=5, IMG_H=3, pixels 1..15 -> 2 outputs, 7.0 and 9.0; column 4 and row 2 never windowed; `done` asserted once.
